// File: rtl/npu_lsu_arb.sv
// Round-robin arbiter sharing one LSU read/write slave port among N_REQ engines.
// One requester and one op are locked until the LSU reports completion.

module npu_lsu_arb_lane #(
  parameter int IW = 2,
  parameter int K  = 0
) (
  input  logic          r_valid,
  input  logic          w_valid,
  input  logic [IW-1:0] ptr,
  output logic          pend,
  output logic          pend_hi
);
  localparam logic [IW-1:0] KI = IW'(K);

  // pend_hi marks lanes at or above the pointer, i.e. ahead in this round
  assign pend    = r_valid | w_valid;
  assign pend_hi = pend & (KI >= ptr);
endmodule

module npu_lsu_arb #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic [N_REQ-1:0]            req_r_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]     req_r_addr_i,
  input  logic [N_REQ-1:0]            req_rd_ready_i,
  output logic [N_REQ-1:0]            req_r_ready_o,
  output logic [DATA_W-1:0]           req_r_data_o,
  input  logic [N_REQ-1:0]            req_w_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]     req_w_addr_i,
  input  logic [N_REQ*DATA_W-1:0]     req_w_data_i,
  input  logic [N_REQ*DATA_W/8-1:0]   req_w_strb_i,
  output logic [N_REQ-1:0]            req_w_ready_o,
  output logic                        lsu_r_valid_o,
  output logic [ADDR_W-1:0]           lsu_r_addr_o,
  output logic                        lsu_rd_ready_o,
  input  logic                        lsu_r_ready_i,
  input  logic [DATA_W-1:0]           lsu_r_data_i,
  output logic                        lsu_w_valid_o,
  output logic [ADDR_W-1:0]           lsu_w_addr_o,
  output logic [DATA_W-1:0]           lsu_w_data_o,
  output logic [DATA_W/8-1:0]         lsu_w_strb_o,
  input  logic                        lsu_w_ready_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        busy_o
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = DATA_W / 8;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  localparam logic       OP_RD  = 1'b0;
  localparam logic       OP_WR  = 1'b1;

  typedef struct packed {
    logic [0:0]    st;
    logic          op;
    logic [IW-1:0] idx;
    logic [IW-1:0] ptr;
  } own_t;

  logic [N_REQ-1:0][ADDR_W-1:0] r_addr, w_addr;
  logic [N_REQ-1:0][DATA_W-1:0] w_data;
  logic [N_REQ-1:0][SW-1:0]     w_strb;

  assign r_addr = req_r_addr_i;
  assign w_addr = req_w_addr_i;
  assign w_data = req_w_data_i;
  assign w_strb = req_w_strb_i;

  own_t             own;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] pend, pend_hi;
  logic [IW-1:0]    pick;
  logic [N_REQ-1:0] pick_oh;
  logic             any, rd_own, wr_own, done;

  genvar k;
  generate
    for (k = 0; k < N_REQ; k++) begin : g_lane
      npu_lsu_arb_lane #(.IW(IW), .K(k)) u_lane (
        .r_valid (req_r_valid_i[k]),
        .w_valid (req_w_valid_i[k]),
        .ptr     (own.ptr),
        .pend    (pend[k]),
        .pend_hi (pend_hi[k])
      );
    end
  endgenerate

  // Lowest pending lane at/after the pointer wins; otherwise wrap to the lowest pending lane.
  always_comb begin
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (pend[i]) pick = IW'(i);
    for (int i = N_REQ - 1; i >= 0; i--)
      if (pend_hi[i]) pick = IW'(i);
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  assign any    = |pend;
  assign rd_own = (own.st == LOCKED) && (own.op == OP_RD);
  assign wr_own = (own.st == LOCKED) && (own.op == OP_WR);
  assign done   = (rd_own & lsu_r_ready_i) | (wr_own & lsu_w_ready_i);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      own.st  <= IDLE;
      own.op  <= OP_RD;
      own.idx <= '0;
      own.ptr <= '0;
      grant   <= '0;
    end else begin
      case (own.st)
        IDLE: begin
          if (any) begin
            own.st  <= LOCKED;
            own.idx <= pick;
            own.op  <= req_r_valid_i[pick] ? OP_RD : OP_WR;
            grant   <= pick_oh;
          end
        end
        default: begin
          // Only LSU completion releases the lock; dropped valids are ignored.
          if (done) begin
            own.st  <= IDLE;
            grant   <= '0;
            own.ptr <= (own.idx == IW'(N_REQ - 1)) ? '0 : own.idx + 1'b1;
          end
        end
      endcase
    end
  end

  assign lsu_r_valid_o  = rd_own & req_r_valid_i[own.idx];
  assign lsu_r_addr_o   = rd_own ? r_addr[own.idx] : '0;
  assign lsu_rd_ready_o = rd_own & req_rd_ready_i[own.idx];

  assign lsu_w_valid_o  = wr_own & req_w_valid_i[own.idx];
  assign lsu_w_addr_o   = wr_own ? w_addr[own.idx] : '0;
  assign lsu_w_data_o   = wr_own ? w_data[own.idx] : '0;
  assign lsu_w_strb_o   = wr_own ? w_strb[own.idx] : '0;

  assign req_r_ready_o  = (rd_own & lsu_r_ready_i) ? grant : '0;
  assign req_w_ready_o  = (wr_own & lsu_w_ready_i) ? grant : '0;
  assign req_r_data_o   = lsu_r_data_i;

  assign grant_o        = grant;
  assign busy_o         = (own.st == LOCKED);
endmodule
